// File: rtl/fila_pkg.sv
// Shared constants and helpers for the fila_param bounded buffer.
package fila_pkg;

   localparam int FILA_MODE_FIFO = 0;
   localparam int FILA_MODE_LIFO = 1;

   // Count must hold 0..DEPTH inclusive.
   function automatic int fila_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fila_ptr.sv
// Modulo-DEPTH pointer register with increment enable; wraps by explicit compare.
module fila_ptr #(
   parameter int DEPTH = 8,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [PW-1:0] ONE  = PW'(1);

   // Pointer advance with wrap from DEPTH-1 back to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (inc) begin
         if (ptr == LAST) begin
            ptr <= '0;
         end else begin
            ptr <= ptr + ONE;
         end
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/fila_param.sv
// Parametrised FIFO/LIFO bounded buffer with count-based full/empty status.
// Optional sticky overflow/underflow flags when FILA_ERR_FLAGS_EN is defined.
module fila_param
   import fila_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int MODE   = FILA_MODE_FIFO
) (
   input  logic                          clock_10khz,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          enqueue_in,
   input  logic                          dequeue_in,
   output logic [DATA_W-1:0]             data_out,
   output logic                          data_valid_out,
   output logic [fila_cnt_w(DEPTH)-1:0]  len_out,
`ifdef FILA_ERR_FLAGS_EN
   output logic                          overflow_err_out,
   output logic                          underflow_err_out,
`endif
   output logic                          full_out,
   output logic                          empty_out
);

   localparam int CW = fila_cnt_w(DEPTH);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [CW-1:0]     count_r;
   logic              full_s;
   logic              empty_s;
   logic              deq_ok_s;
   logic              enq_ok_s;
   logic [AW-1:0]     rd_addr_s;
   logic [AW-1:0]     wr_addr_s;

   assign full_s    = (count_r == FULL_C);
   assign empty_s   = (count_r == '0);
   assign full_out  = full_s;
   assign empty_out = empty_s;
   assign len_out   = count_r;

   // A dequeue frees a slot, so enqueue is accepted when full if paired with one.
   assign deq_ok_s = dequeue_in && !empty_s;
   assign enq_ok_s = enqueue_in && (!full_s || deq_ok_s);

   generate
      if (MODE == FILA_MODE_FIFO) begin : g_fifo
         logic [AW-1:0] rd_ptr_s;
         logic [AW-1:0] wr_ptr_s;

         fila_ptr #(.DEPTH(DEPTH), .PW(AW)) u_rd_ptr (
            .clk   (clock_10khz),
            .reset (reset),
            .inc   (deq_ok_s),
            .ptr   (rd_ptr_s)
         );

         fila_ptr #(.DEPTH(DEPTH), .PW(AW)) u_wr_ptr (
            .clk   (clock_10khz),
            .reset (reset),
            .inc   (enq_ok_s),
            .ptr   (wr_ptr_s)
         );

         assign rd_addr_s = rd_ptr_s;
         assign wr_addr_s = wr_ptr_s;
      end else begin : g_lifo
         logic [CW-1:0] top_s;

         // On push+pop the new element replaces the popped top in place.
         assign top_s     = count_r - ONE_C;
         assign rd_addr_s = AW'(top_s);
         assign wr_addr_s = deq_ok_s ? AW'(top_s) : AW'(count_r);
      end
   endgenerate

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clock_10khz) begin
      if (!reset && enq_ok_s) begin
         mem_r[wr_addr_s] <= data_in;
      end
   end

   // Element count.
   always_ff @(posedge clock_10khz) begin
      if (reset) begin
         count_r <= '0;
      end else if (enq_ok_s && !deq_ok_s) begin
         count_r <= count_r + ONE_C;
      end else if (deq_ok_s && !enq_ok_s) begin
         count_r <= count_r - ONE_C;
      end else begin
         count_r <= count_r;
      end
   end

   // Registered read port and its one-cycle valid strobe.
   always_ff @(posedge clock_10khz) begin
      if (reset) begin
         data_out       <= '0;
         data_valid_out <= 1'b0;
      end else begin
         data_valid_out <= deq_ok_s;
         if (deq_ok_s) begin
            data_out <= mem_r[rd_addr_s];
         end else begin
            data_out <= data_out;
         end
      end
   end

`ifdef FILA_ERR_FLAGS_EN
   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clock_10khz) begin
      if (reset) begin
         overflow_err_out  <= 1'b0;
         underflow_err_out <= 1'b0;
      end else begin
         overflow_err_out  <= overflow_err_out  | (enqueue_in && !enq_ok_s);
         underflow_err_out <= underflow_err_out | (dequeue_in && empty_s);
      end
   end
`endif

endmodule

// File: tb/tb_fila_param.sv
// Directed self-checking bench for fila_param: FIFO/LIFO at depths 8 and 4.
module tb_fila_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enq = 1'b0;
   logic       deq = 1'b0;
   logic [7:0] din = 8'h00;

   logic [7:0] f8_dout, l8_dout, f4_dout, l4_dout;
   logic       f8_v, l8_v, f4_v, l4_v;
   logic [3:0] f8_len, l8_len;
   logic [2:0] f4_len, l4_len;
   logic       f8_full, l8_full, f4_full, l4_full;
   logic       f8_emp, l8_emp, f4_emp, l4_emp;
`ifdef FILA_ERR_FLAGS_EN
   logic       f8_ov, f8_un, l8_ov, l8_un, f4_ov, f4_un, l4_ov, l4_un;
`endif

   int total = 0;
   int bad   = 0;

   always #50 clk = ~clk;

   fila_param #(.DATA_W(8), .DEPTH(8), .MODE(0)) u_f8 (
      .clock_10khz(clk), .reset(rst), .data_in(din), .enqueue_in(enq), .dequeue_in(deq),
      .data_out(f8_dout), .data_valid_out(f8_v), .len_out(f8_len),
`ifdef FILA_ERR_FLAGS_EN
      .overflow_err_out(f8_ov), .underflow_err_out(f8_un),
`endif
      .full_out(f8_full), .empty_out(f8_emp));

   fila_param #(.DATA_W(8), .DEPTH(8), .MODE(1)) u_l8 (
      .clock_10khz(clk), .reset(rst), .data_in(din), .enqueue_in(enq), .dequeue_in(deq),
      .data_out(l8_dout), .data_valid_out(l8_v), .len_out(l8_len),
`ifdef FILA_ERR_FLAGS_EN
      .overflow_err_out(l8_ov), .underflow_err_out(l8_un),
`endif
      .full_out(l8_full), .empty_out(l8_emp));

   fila_param #(.DATA_W(8), .DEPTH(4), .MODE(0)) u_f4 (
      .clock_10khz(clk), .reset(rst), .data_in(din), .enqueue_in(enq), .dequeue_in(deq),
      .data_out(f4_dout), .data_valid_out(f4_v), .len_out(f4_len),
`ifdef FILA_ERR_FLAGS_EN
      .overflow_err_out(f4_ov), .underflow_err_out(f4_un),
`endif
      .full_out(f4_full), .empty_out(f4_emp));

   fila_param #(.DATA_W(8), .DEPTH(4), .MODE(1)) u_l4 (
      .clock_10khz(clk), .reset(rst), .data_in(din), .enqueue_in(enq), .dequeue_in(deq),
      .data_out(l4_dout), .data_valid_out(l4_v), .len_out(l4_len),
`ifdef FILA_ERR_FLAGS_EN
      .overflow_err_out(l4_ov), .underflow_err_out(l4_un),
`endif
      .full_out(l4_full), .empty_out(l4_emp));

   // Drive one cycle of inputs on the falling edge; return #1 after the rising edge.
   task automatic cyc(input logic r, input logic e, input logic d, input logic [7:0] v);
      @(negedge clk);
      rst = r;
      enq = e;
      deq = d;
      din = v;
      @(posedge clk);
      #1;
      rst = 1'b0;
      enq = 1'b0;
      deq = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_seq [11];
      logic [7:0] fexp [4];
      logic [7:0] lexp [4];

      // Reset state
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("rst_len", f8_len, 4'd0);
      chk("rst_empty", f8_emp, 1'b1);
      chk("rst_full", f8_full, 1'b0);
      chk("rst_dout", f8_dout, 8'h00);
      chk("rst_valid", f8_v, 1'b0);
`ifdef FILA_ERR_FLAGS_EN
      chk("rst_ov", f4_ov, 1'b0);
      chk("rst_un", f4_un, 1'b0);
`endif

      // Reset mid-operation overrides a concurrent dequeue
      cyc(1'b0, 1'b1, 1'b0, 8'h11);
      cyc(1'b0, 1'b1, 1'b0, 8'h22);
      cyc(1'b0, 1'b1, 1'b0, 8'h33);
      chk("mid_len3", f8_len, 4'd3);
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      chk("mid_len", f8_len, 4'd0);
      chk("mid_empty", f8_emp, 1'b1);
      chk("mid_dout", f8_dout, 8'h00);
      chk("mid_valid", f8_v, 1'b0);

      // FIFO ordering and pointer wrap, depth 8
      for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
      chk("wrap_full", f8_full, 1'b1);
      chk("wrap_len8", f8_len, 4'd8);
      chk("wrap_notempty", f8_emp, 1'b0);
      for (int i = 0; i < 8; i++) exp_seq[i] = 8'(i + 1);
      exp_seq[8] = 8'hA0; exp_seq[9] = 8'hA1; exp_seq[10] = 8'hA2;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("wrap_d%0d", i), f8_dout, exp_seq[i]);
         chk($sformatf("wrap_v%0d", i), f8_v, 1'b1);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
      chk("wrap_refull", f8_full, 1'b1);
      for (int i = 3; i < 11; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("wrap_d%0d", i), f8_dout, exp_seq[i]);
      end
      chk("wrap_empty", f8_emp, 1'b1);

      // LIFO ordering, depth 8
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, 8'h10);
      cyc(1'b0, 1'b1, 1'b0, 8'h20);
      cyc(1'b0, 1'b1, 1'b0, 8'h30);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("lifo_d0", l8_dout, 8'h30);
      chk("lifo_v0", l8_v, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("lifo_d1", l8_dout, 8'h20);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("lifo_d2", l8_dout, 8'h10);
      chk("lifo_empty", l8_emp, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      chk("lifo_strobe_drop", l8_v, 1'b0);

      // Overflow and underflow, depth 4
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
      chk("ovf_len", f4_len, 3'd4);
      chk("ovf_full", f4_full, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("ovf_d%0d", i), f4_dout, 8'(i));
         chk($sformatf("ovf_v%0d", i), f4_v, 1'b1);
      end
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("unf_valid", f4_v, 1'b0);
      chk("unf_dout", f4_dout, 8'h04);
      chk("unf_len", f4_len, 3'd0);
      chk("unf_empty", f4_emp, 1'b1);
      chk("unf_lifo_dout", l4_dout, 8'h01);
`ifdef FILA_ERR_FLAGS_EN
      chk("flag_ov", f4_ov, 1'b1);
      chk("flag_un", f4_un, 1'b1);
`endif

      // Simultaneous enqueue+dequeue when full
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
      cyc(1'b0, 1'b1, 1'b1, 8'h09);
      chk("sf_fifo_dout", f4_dout, 8'h01);
      chk("sf_fifo_v", f4_v, 1'b1);
      chk("sf_fifo_len", f4_len, 3'd4);
      chk("sf_lifo_dout", l4_dout, 8'h04);
      chk("sf_lifo_len", l4_len, 3'd4);
      fexp[0] = 8'h02; fexp[1] = 8'h03; fexp[2] = 8'h04; fexp[3] = 8'h09;
      lexp[0] = 8'h09; lexp[1] = 8'h03; lexp[2] = 8'h02; lexp[3] = 8'h01;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
         chk($sformatf("sf_fifo_drain%0d", i), f4_dout, fexp[i]);
         chk($sformatf("sf_lifo_drain%0d", i), l4_dout, lexp[i]);
      end

      // Simultaneous enqueue+dequeue when empty: no bypass
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b1, 8'h55);
      chk("se_valid", f4_v, 1'b0);
      chk("se_len", f4_len, 3'd1);
      chk("se_dout", f4_dout, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("se_next_dout", f4_dout, 8'h55);
      chk("se_next_valid", f4_v, 1'b1);
      chk("se_lifo_dout", l4_dout, 8'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
